add_accu: RTL and testbench

- 4-bit adder/accumulator datapath block.
- Combinationally adds input a to either input b or an internal accumulator register, selected by sel.
- The accumulator captures the adder result on every rising clock edge, so repeated sel=1 cycles accumulate a.
- Used as a small arithmetic building block with purely combinational sum/carry outputs and one state register.

---
 rtl/add_accu_pkg.sv | 12 +
 rtl/add_accu_adder.sv | 26 ++
 rtl/add_accu.sv | 52 +++++
 tb/tb_add_accu.sv | 131 +++++++++++++
 4 files changed

// File: rtl/add_accu_pkg.sv
// add_accu_pkg
// Shared constants for the add_accu adder/accumulator block.
//   ADD_ACCU_WIDTH : default operand/sum/accumulator width
//   SEL_B, SEL_ACC : operand select encodings for the sel port
package add_accu_pkg;

    localparam int ADD_ACCU_WIDTH = 4;

    localparam logic SEL_B   = 1'b0;
    localparam logic SEL_ACC = 1'b1;

endpackage

// File: rtl/add_accu_adder.sv
// add_accu_adder
// Unsigned WIDTH-bit adder returning the low WIDTH bits and the carry-out.
//   a_i     : first addend
//   b_i     : second addend
//   sum_o   : low WIDTH bits of a_i + b_i
//   carry_o : bit WIDTH of a_i + b_i
module add_accu_adder
    import add_accu_pkg::*;
#(
    parameter int WIDTH = ADD_ACCU_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o
);

    logic [WIDTH:0] full_sum;

    // Zero-extend both operands so the carry lands in the top bit.
    assign full_sum = {1'b0, a_i} + {1'b0, b_i};

    assign sum_o   = full_sum[WIDTH-1:0];
    assign carry_o = full_sum[WIDTH];

endmodule

// File: rtl/add_accu.sv
// add_accu
// Adds a to either b or the internal accumulator (chosen by sel); sum/carry
// are combinational. The accumulator captures sum on every rising ck edge,
// regardless of sel, and is cleared asynchronously by rst_n.
//   ck     : clock
//   rst_n  : asynchronous active-low reset, clears the accumulator
//   a      : first addend
//   b      : second addend when sel = SEL_B
//   sel    : SEL_B selects b, SEL_ACC selects the accumulator
//   sum    : low WIDTH bits of a + operand
//   carry  : carry-out of a + operand (never stored)
module add_accu
    import add_accu_pkg::*;
#(
    parameter int WIDTH = ADD_ACCU_WIDTH
) (
    input  logic             ck,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    logic [WIDTH-1:0] accu_q;
    logic [WIDTH-1:0] accu_d;
    logic [WIDTH-1:0] op;

    assign op = (sel == SEL_ACC) ? accu_q : b;

    add_accu_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a_i     (a),
        .b_i     (op),
        .sum_o   (sum),
        .carry_o (carry)
    );

    // Carry is deliberately dropped: the register keeps only the wrapped sum.
    assign accu_d = sum;

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            accu_q <= '0;
        end else begin
            accu_q <= accu_d;
        end
    end

endmodule

// File: tb/tb_add_accu.sv
module tb_add_accu;

    localparam int W = 4;

    logic         ck;
    logic         rst_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sel;
    logic [W-1:0] sum;
    logic         carry;

    add_accu #(.WIDTH(W)) dut (
        .ck    (ck),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .sel   (sel),
        .sum   (sum),
        .carry (carry)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    typedef struct {
        int unsigned exp_sum;
        bit          exp_carry;
        string       name;
    } exp_t;

    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    bit stim_done = 0;

    // Reference model: accumulator value as a plain integer.
    int unsigned m_acc = 0;

    // One stimulus step: lets the model observe the rising edge (capture of
    // the previous cycle's result if reset was high), then applies new inputs
    // shortly after the edge and queues the expected combinational result.
    task automatic step(input int unsigned ta, input int unsigned tb_v,
                        input bit ts, input bit tr, input string nm);
        int unsigned total;
        exp_t e;
        @(posedge ck);
        if (rst_n === 1'b1)
            m_acc = (a + (sel ? m_acc : b)) % 16;
        #1;
        a     = ta[W-1:0];
        b     = tb_v[W-1:0];
        sel   = ts;
        rst_n = tr;
        if (!tr) m_acc = 0;
        total = ta + (ts ? m_acc : tb_v);
        e.exp_sum   = total % 16;
        e.exp_carry = (total >= 16);
        e.name      = nm;
        exp_q.push_back(e);
    endtask

    // Monitor: compares whatever is pending on the falling edge, well away
    // from the input changes and the capturing edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge ck);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (sum !== e.exp_sum[W-1:0] || carry !== e.exp_carry) begin
                    n_fail++;
                    $display("FAIL %s: got sum=%0d carry=%0b, want sum=%0d carry=%0b",
                             e.name, sum, carry, e.exp_sum, e.exp_carry);
                end
            end
        end
    end

    initial begin
        a = '0; b = '0; sel = 1'b0; rst_n = 1'b0;

        // reset / initial
        step(0, 0, 0, 0, "reset_sel0");
        step(0, 0, 1, 0, "reset_sel1");
        step(0, 0, 0, 1, "release");
        // plain adds
        step(5, 10, 0, 1, "add_5_10");
        step(2, 14, 0, 1, "wrap_2_14");
        step(2, 15, 0, 1, "wrap_2_15");
        // accumulate a=3 from a cleared register
        step(3, 0, 1, 0, "acc_reset");
        for (int i = 0; i < 7; i++) step(3, 0, 1, 1, "acc_3");
        // load then accumulate
        step(4, 5, 0, 1, "load_4_5");
        step(1, 0, 1, 1, "acc_after_load");
        step(1, 0, 1, 1, "acc_after_load2");
        // reset mid-accumulation, then resume
        step(1, 0, 1, 0, "mid_reset");
        step(1, 0, 1, 1, "post_reset_first");
        step(1, 0, 1, 1, "post_reset_second");
        step(1, 0, 1, 1, "post_reset_third");

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(15), $urandom_range(15), 1'($urandom_range(1)),
                 ($urandom_range(19) != 0), "random");
        end

        @(negedge ck);
        @(negedge ck);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        stim_done = 1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got no completion, want completion");
        $fatal(1, "timeout");
    end

endmodule
